mux_key_default: RTL and testbench

- Parameterised key-lookup multiplexer: compares `key` against NR_KEY packed key/data pairs and outputs the matching data, or `default_out` when no key matches.
- Used by the register file to select CSR read data (mstatus/mtvec/mepc/mcause by 12-bit CSR address) and as a generic decoder mux elsewhere in the core.
- Provides a combinational result plus a registered copy for timing-critical consumers.

---
 rtl/mux_key_default.sv | 91 +++++++++
 tb/tb_mux_key_default.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mux_key_default.sv
// ---------------------------------------------------------------------------
// mux_key_default
//   Key-lookup multiplexer. Compares `key` against NR_KEY packed key/data
//   pairs and returns the data of the matching entry, or `default_out` when
//   nothing matches. When several entries match, the lowest index wins.
//   Data is never OR-merged.
//   A registered copy of the result is provided for timing-critical users.
//
//   Table layout (PAIR_LEN = KEY_LEN + DATA_LEN):
//     entry i = lut[PAIR_LEN*(i+1)-1 : PAIR_LEN*i], entry 0 least significant
//     within an entry: {key[KEY_LEN-1:0], data[DATA_LEN-1:0]}
//
// Ports:
//   clock        in   system clock, registered outputs update on rising edge
//   reset        in   asynchronous active-high, clears out_q / hit_q
//   key          in   KEY_LEN     lookup key
//   default_out  in   DATA_LEN    result when no entry matches
//   lut          in   NR_KEY*PAIR_LEN packed key/data table
//   out          out  DATA_LEN    combinational lookup result
//   hit          out  1           combinational, any entry matched
//   out_q        out  DATA_LEN    out, one cycle late
//   hit_q        out  1           hit, one cycle late
// ---------------------------------------------------------------------------

// Per-entry compare: splits one pair into key/data and flags an exact match.
module mux_key_default_entry #(
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN+DATA_LEN-1:0] pair,
    input  logic [KEY_LEN-1:0]          key,
    output logic                        match,
    output logic [DATA_LEN-1:0]         data
);
    assign match = (pair[KEY_LEN+DATA_LEN-1 -: KEY_LEN] == key);
    assign data  = pair[DATA_LEN-1:0];
endmodule

module mux_key_default #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [NR_KEY-1:0]               match;
    logic [NR_KEY-1:0][DATA_LEN-1:0] data;

    for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
        mux_key_default_entry #(
            .KEY_LEN  (KEY_LEN),
            .DATA_LEN (DATA_LEN)
        ) u_entry (
            .pair  (lut[PAIR_LEN*g +: PAIR_LEN]),
            .key   (key),
            .match (match[g]),
            .data  (data[g])
        );
    end

    assign hit = |match;

    // Walk from the top entry down so the lowest matching index is the
    // last assignment and therefore wins.
    always_comb begin
        out = default_out;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (match[i]) out = data[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= out;
            hit_q <= hit;
        end
    end
endmodule

// File: tb/tb_mux_key_default.sv
module tb_mux_key_default;
    localparam int NK = 4, KL = 12, DL = 32, PL = KL + DL;

    logic              clock = 1'b0;
    logic              reset;
    logic [KL-1:0]     key;
    logic [DL-1:0]     dflt;
    logic [NK*PL-1:0]  lut;
    logic [DL-1:0]     out, out_q;
    logic              hit, hit_q;

    // single-entry instance
    logic              key1;
    logic [7:0]        dflt1;
    logic [8:0]        lut1;
    logic [7:0]        out1, out1_q;
    logic              hit1, hit1_q;

    int total = 0;
    int bad   = 0;
    logic [DL:0] sb_q[$];   // {hit, out} expected on out_q/hit_q

    always #5 clock = ~clock;

    mux_key_default #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) u_dut (
        .clock(clock), .reset(reset), .key(key), .default_out(dflt), .lut(lut),
        .out(out), .hit(hit), .out_q(out_q), .hit_q(hit_q)
    );

    mux_key_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8)) u_dut1 (
        .clock(clock), .reset(reset), .key(key1), .default_out(dflt1), .lut(lut1),
        .out(out1), .hit(hit1), .out_q(out1_q), .hit_q(hit1_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan upward from entry 0, first match is taken.
    function automatic logic [DL:0] ref_lookup(input logic [NK*PL-1:0] t,
                                               input logic [KL-1:0] k,
                                               input logic [DL-1:0] d);
        logic [DL:0] r;
        logic found;
        r = {1'b0, d};
        found = 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (!found && t[PL*i+DL +: KL] == k) begin
                r = {1'b1, t[PL*i +: DL]};
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Drive at negedge, check comb, push expectation, pop after next edge.
    task automatic step(input logic [KL-1:0] k, input logic [DL-1:0] d);
        logic [DL:0] e, q;
        @(negedge clock);
        key  = k;
        dflt = d;
        #1;
        e = ref_lookup(lut, k, d);
        chk("comb_out", out, e[DL-1:0]);
        chk("comb_hit", hit, e[DL]);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            q = sb_q.pop_front();
            chk("reg_out", out_q, q[DL-1:0]);
            chk("reg_hit", hit_q, q[DL]);
        end
    endtask

    logic [NK*PL-1:0] lut_main;
    logic [KL-1:0]    keys[5];

    initial begin
        lut_main = {12'h300, 32'h1800, 12'h305, 32'h8000_0000,
                    12'h341, 32'h1234, 12'h342, 32'h0000_000B};
        lut   = lut_main;
        reset = 1'b1;
        key   = 12'h341;
        dflt  = '0;
        key1  = 1'b1;
        dflt1 = 8'h33;
        lut1  = {1'b1, 8'h5A};
        #1;
        chk("rst_out_q", out_q, 0);
        chk("rst_hit_q", hit_q, 0);

        // combinational path is live during reset
        chk("k341_out", out, 32'h1234);
        chk("k341_hit", hit, 1);
        key = 12'h300; #1;
        chk("k300_out", out, 32'h1800);
        key = 12'h305; #1;
        chk("k305_out", out, 32'h8000_0000);
        key = 12'h344; dflt = 32'hDEAD; #1;
        chk("miss_out", out, 32'hDEAD);
        chk("miss_hit", hit, 0);
        key = 12'h000; #1;
        chk("zero_out", out, 32'hDEAD);
        key = 12'hFFF; #1;
        chk("ones_hit", hit, 0);

        // duplicate keys: entry 0 and entry 2 both 0x305
        lut = {12'h300, 32'h1800, 12'h305, 32'hBBBB,
               12'h341, 32'h1234, 12'h305, 32'hAAAA};
        key = 12'h305; #1;
        chk("dup_out", out, 32'hAAAA);
        chk("dup_hit", hit, 1);
        lut = lut_main;

        // single-entry instance
        #1;
        chk("n1_k1_out", out1, 8'h5A);
        chk("n1_k1_hit", hit1, 1);
        key1 = 1'b0; #1;
        chk("n1_k0_out", out1, 8'h33);
        chk("n1_k0_hit", hit1, 0);

        @(negedge clock);
        reset = 1'b0;

        // registered path: 0x300 then 0x342 ahead of edge N
        step(12'h300, 32'h0);
        @(negedge clock);
        key = 12'h342; #1;
        chk("pre_edge_out", out, 32'hB);
        chk("pre_edge_out_q", out_q, 32'h1800);
        @(posedge clock); #1;
        chk("post_edge_out_q", out_q, 32'hB);
        chk("post_edge_hit_q", hit_q, 1);

        // async reset between edges
        #2 reset = 1'b1;
        #1;
        chk("async_out_q", out_q, 0);
        chk("async_hit_q", hit_q, 0);
        chk("async_out", out, 32'hB);
        chk("async_n1_q", out1_q, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rel_out_q", out_q, 32'hB);
        chk("rel_hit_q", hit_q, 1);
        chk("rel_n1_q", out1_q, 8'h33);

        // scoreboard over mixed hit/miss keys
        keys[0] = 12'h300; keys[1] = 12'h305; keys[2] = 12'h341;
        keys[3] = 12'h342; keys[4] = 12'h7AB;
        for (int n = 0; n < 24; n++) begin
            logic [KL-1:0] k;
            k = (n % 3 == 2) ? KL'($urandom) : keys[$urandom_range(0, 4)];
            step(k, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "timeout");
    end
endmodule
